// File: rtl/player_controller_if.sv
// Signal bundle between the player controller and its surroundings (buttons,
// collision compare, blast sources, VGA pixel path).
interface player_controller_if #(
  parameter int CW         = 10,
  parameter int NUM_BLASTS = 2,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16
);
  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  logic                     btn_l;
  logic                     btn_r;
  logic                     btn_u;
  logic                     btn_d;
  logic [3:0]               blocked;
  logic [NUM_BLASTS-1:0]    blast_valid;
  logic [NUM_BLASTS*CW-1:0] blast_x;
  logic [NUM_BLASTS*CW-1:0] blast_y;
  logic [CW-1:0]            v_x;
  logic [CW-1:0]            v_y;
  logic [CW-1:0]            pos_x;
  logic [CW-1:0]            pos_y;
  logic [1:0]               facing;
  logic                     moving;
  logic [3:0]               lives;
  logic                     hit_pulse;
  logic                     invuln;
  logic                     game_over;
  logic                     sprite_on;
  logic [COL_W-1:0]         sprite_col;
  logic [ROW_W-1:0]         sprite_row;

  modport master (
    output btn_l, btn_r, btn_u, btn_d, blocked, blast_valid, blast_x, blast_y, v_x, v_y,
    input  pos_x, pos_y, facing, moving, lives, hit_pulse, invuln, game_over,
           sprite_on, sprite_col, sprite_row
  );

  modport slave (
    input  btn_l, btn_r, btn_u, btn_d, blocked, blast_valid, blast_x, blast_y, v_x, v_y,
    output pos_x, pos_y, facing, moving, lives, hit_pulse, invuln, game_over,
           sprite_on, sprite_col, sprite_row
  );
endinterface

// File: rtl/player_controller.sv
// Player sprite controller: stepped movement FSM, multi-channel blast hit test,
// lives/respawn, sprite window. Optional post-respawn immunity via `INVULN_EN.
module player_controller #(
  parameter int CW          = 10,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int MIN_X       = 143,
  parameter int MAX_X       = 784,
  parameter int MIN_Y       = 34,
  parameter int MAX_Y       = 516,
  parameter int START_X     = 143,
  parameter int START_Y     = 34,
  parameter int STEP_DIV    = 1400000,
  parameter int NUM_BLASTS  = 2,
  parameter int BLAST_TILE  = 16,
  parameter int BLAST_REACH = 48,
  parameter int LIVES       = 3,
  parameter int INVULN_CYC  = 50000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  player_controller_if.slave    pc
);
  localparam int CNT_W = $clog2(STEP_DIV);
  localparam int SW    = CW + 2;
  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  if (STEP_DIV < 2 || LIVES < 1 || LIVES > 15 || INVULN_CYC < 1) begin : g_bad_param
    $error("player_controller: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DEAD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       facing_q, facing_d;
  logic [CW-1:0]    pos_x_q, pos_x_d;
  logic [CW-1:0]    pos_y_q, pos_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       lives_q, lives_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             game_over_q, game_over_d;

  logic [3:0]       btn;
  logic             any_hit;
  logic             take_hit;
  logic             invuln_act;

  logic signed [SW-1:0] sx0, sx1, sy0, sy1;
  logic signed [SW-1:0] bx, by;

  function automatic logic overlap(input logic signed [SW-1:0] a0, a1, b0, b1);
    return (a0 <= b1) && (b0 <= a1);
  endfunction

  function automatic logic [1:0] first_dir(input logic [3:0] b);
    if (b[0])      return 2'd0;
    else if (b[1]) return 2'd1;
    else if (b[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign btn = {pc.btn_d, pc.btn_u, pc.btn_r, pc.btn_l};

  // Widened signed boxes so bx-REACH near zero goes negative instead of wrapping.
  assign sx0 = $signed({2'b00, pos_x_q});
  assign sy0 = $signed({2'b00, pos_y_q});
  assign sx1 = sx0 + SW'(SPR_W - 1);
  assign sy1 = sy0 + SW'(SPR_H - 1);

  always_comb begin
    any_hit = 1'b0;
    bx      = '0;
    by      = '0;
    for (int i = 0; i < NUM_BLASTS; i++) begin
      bx = $signed({2'b00, pc.blast_x[i*CW +: CW]});
      by = $signed({2'b00, pc.blast_y[i*CW +: CW]});
      if (pc.blast_valid[i] &&
          ((overlap(sx0, sx1, bx - SW'(BLAST_REACH), bx + SW'(BLAST_TILE - 1 + BLAST_REACH)) &&
            overlap(sy0, sy1, by, by + SW'(BLAST_TILE - 1))) ||
           (overlap(sx0, sx1, bx, bx + SW'(BLAST_TILE - 1)) &&
            overlap(sy0, sy1, by - SW'(BLAST_REACH), by + SW'(BLAST_TILE - 1 + BLAST_REACH)))))
        any_hit = 1'b1;
    end
  end

  assign take_hit = any_hit && (state_q != S_DEAD) && !invuln_act;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    facing_d    = facing_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    cnt_d       = cnt_q;
    lives_d     = lives_q;
    hit_pulse_d = 1'b0;
    game_over_d = game_over_q;
    if (take_hit) begin
      hit_pulse_d = 1'b1;
      lives_d     = lives_q - 4'd1;
      if (lives_q == 4'd1) begin
        state_d     = S_DEAD;
        game_over_d = 1'b1;
      end else begin
        state_d = S_IDLE;
        pos_x_d = CW'(START_X);
        pos_y_d = CW'(START_Y);
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|btn) begin
            state_d  = S_MOVE;
            dir_d    = first_dir(btn);
            facing_d = first_dir(btn);
            cnt_d    = '0;
          end
        end
        S_MOVE: begin
          if (!btn[dir_q]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STEP_DIV - 1)) begin
            cnt_d = '0;
            // A step that would leave the playfield is simply dropped.
            if (!pc.blocked[dir_q]) begin
              case (dir_q)
                2'd0: if (pos_x_q > CW'(MIN_X))         pos_x_d = pos_x_q - CW'(1);
                2'd1: if (pos_x_q < CW'(MAX_X - SPR_W)) pos_x_d = pos_x_q + CW'(1);
                2'd2: if (pos_y_q > CW'(MIN_Y))         pos_y_d = pos_y_q - CW'(1);
                default: if (pos_y_q < CW'(MAX_Y - SPR_H)) pos_y_d = pos_y_q + CW'(1);
              endcase
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DEAD: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dir_q       <= 2'b11;
      facing_q    <= 2'b11;
      pos_x_q     <= CW'(START_X);
      pos_y_q     <= CW'(START_Y);
      cnt_q       <= '0;
      lives_q     <= 4'(LIVES);
      hit_pulse_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      facing_q    <= facing_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      cnt_q       <= cnt_d;
      lives_q     <= lives_d;
      hit_pulse_q <= hit_pulse_d;
      game_over_q <= game_over_d;
    end
  end

`ifdef INVULN_EN
  localparam int INV_W = $clog2(INVULN_CYC + 1);
  logic [INV_W-1:0] inv_q, inv_d;

  // Armed only on a respawn; a fatal hit leaves it idle and DEAD freezes it.
  always_comb begin
    inv_d = inv_q;
    if (take_hit && lives_q != 4'd1)
      inv_d = INV_W'(INVULN_CYC);
    else if (state_q != S_DEAD && inv_q != '0)
      inv_d = inv_q - INV_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inv_q <= '0;
    else          inv_q <= inv_d;
  end

  assign invuln_act = |inv_q;
`else
  assign invuln_act = 1'b0;
`endif

  assign pc.pos_x     = pos_x_q;
  assign pc.pos_y     = pos_y_q;
  assign pc.facing    = facing_q;
  assign pc.moving    = (state_q == S_MOVE);
  assign pc.lives     = lives_q;
  assign pc.hit_pulse = hit_pulse_q;
  assign pc.invuln    = invuln_act;
  assign pc.game_over = game_over_q;

  assign pc.sprite_on = ({1'b0, pc.v_x} >= {1'b0, pos_x_q}) &&
                        ({1'b0, pc.v_x} <= {1'b0, pos_x_q} + (CW+1)'(SPR_W - 1)) &&
                        ({1'b0, pc.v_y} >= {1'b0, pos_y_q}) &&
                        ({1'b0, pc.v_y} <= {1'b0, pos_y_q} + (CW+1)'(SPR_H - 1));
  assign pc.sprite_col = COL_W'(pc.v_x - pos_x_q);
  assign pc.sprite_row = ROW_W'(pc.v_y - pos_y_q);

endmodule

// File: tb/tb_player_controller.sv
// Bench for player_controller: directed scenarios with literal expectations plus
// randomized episodes checked every cycle against a behavioural model.
module tb_player_controller;
  localparam int CW = 10, SPR_W = 16, SPR_H = 16;
  localparam int MIN_X = 143, MAX_X = 784, MIN_Y = 34, MAX_Y = 516;
  localparam int START_X = 143, START_Y = 34, STEP_DIV = 4, NB = 2;
  localparam int TILE = 16, REACH = 48, LIVES = 3, INV_CYC = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  player_controller_if #(.CW(CW), .NUM_BLASTS(NB), .SPR_W(SPR_W), .SPR_H(SPR_H)) bus ();

  player_controller #(
    .CW(CW), .SPR_W(SPR_W), .SPR_H(SPR_H), .MIN_X(MIN_X), .MAX_X(MAX_X),
    .MIN_Y(MIN_Y), .MAX_Y(MAX_Y), .START_X(START_X), .START_Y(START_Y),
    .STEP_DIV(STEP_DIV), .NUM_BLASTS(NB), .BLAST_TILE(TILE), .BLAST_REACH(REACH),
    .LIVES(LIVES), .INVULN_CYC(INV_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pc(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_x, m_y, m_face, m_dir, m_cnt, m_lives, m_inv;
  bit m_move, m_dead, m_hp;

  function automatic bit blast_hits(input int px, input int py, input int bx, input int by);
    bit h_arm, v_arm;
    h_arm = (px <= bx + TILE - 1 + REACH) && (px + SPR_W - 1 >= bx - REACH) &&
            (py <= by + TILE - 1) && (py + SPR_H - 1 >= by);
    v_arm = (px <= bx + TILE - 1) && (px + SPR_W - 1 >= bx) &&
            (py <= by + TILE - 1 + REACH) && (py + SPR_H - 1 >= by - REACH);
    return h_arm || v_arm;
  endfunction

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_face = 3; m_dir = 3; m_cnt = 0;
    m_lives = LIVES; m_inv = 0; m_move = 0; m_dead = 0; m_hp = 0;
  endtask

  task automatic model_step();
    logic [3:0] b;
    bit hit;
    int bx, by;
    b = {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l};
    hit = 0;
    for (int i = 0; i < NB; i++) begin
      bx = int'(bus.blast_x[i*CW +: CW]);
      by = int'(bus.blast_y[i*CW +: CW]);
      if (bus.blast_valid[i] && blast_hits(m_x, m_y, bx, by)) hit = 1;
    end
    m_hp = 0;
    if (hit && !m_dead && m_inv == 0) begin
      m_hp = 1;
      m_lives = m_lives - 1;
      if (m_lives == 0) begin
        m_dead = 1; m_move = 0;
      end else begin
        m_x = START_X; m_y = START_Y; m_move = 0; m_cnt = 0;
`ifdef INVULN_EN
        m_inv = INV_CYC;
`endif
      end
    end else if (!m_dead) begin
      if (m_inv > 0) m_inv = m_inv - 1;
      if (!m_move) begin
        for (int d = 0; d < 4; d++)
          if (b[d]) begin m_move = 1; m_dir = d; m_face = d; m_cnt = 0; break; end
      end else if (!b[m_dir]) begin
        m_move = 0;
      end else if (m_cnt == STEP_DIV - 1) begin
        m_cnt = 0;
        if (!bus.blocked[m_dir]) begin
          case (m_dir)
            0: if (m_x - 1 >= MIN_X) m_x = m_x - 1;
            1: if (m_x + 1 <= MAX_X - SPR_W) m_x = m_x + 1;
            2: if (m_y - 1 >= MIN_Y) m_y = m_y - 1;
            default: if (m_y + 1 <= MAX_Y - SPR_H) m_y = m_y + 1;
          endcase
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_on;
      int vx, vy;
      vx = int'(bus.v_x);
      vy = int'(bus.v_y);
      chk("pos_x", bus.pos_x, m_x);
      chk("pos_y", bus.pos_y, m_y);
      chk("facing", bus.facing, m_face);
      chk("moving", bus.moving, int'(m_move && !m_dead));
      chk("lives", bus.lives, m_lives);
      chk("hit_pulse", bus.hit_pulse, int'(m_hp));
      chk("invuln", bus.invuln, int'(m_inv != 0));
      chk("game_over", bus.game_over, int'(m_dead));
      exp_on = (vx >= m_x) && (vx <= m_x + SPR_W - 1) && (vy >= m_y) && (vy <= m_y + SPR_H - 1);
      chk("sprite_on", bus.sprite_on, int'(exp_on));
      if (exp_on) begin
        chk("sprite_col", bus.sprite_col, vx - m_x);
        chk("sprite_row", bus.sprite_row, vy - m_y);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.btn_l = 0; bus.btn_r = 0; bus.btn_u = 0; bus.btn_d = 0;
    bus.blocked = '0; bus.blast_valid = '0; bus.blast_x = '0; bus.blast_y = '0;
    bus.v_x = '0; bus.v_y = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic set_blast(input int ch, input int x, input int y);
    bus.blast_x[ch*CW +: CW] = CW'(x);
    bus.blast_y[ch*CW +: CW] = CW'(y);
    bus.blast_valid[ch] = 1'b1;
  endtask

  function automatic logic [CW-1:0] near(input int c, input int span);
    int v;
    v = c + int'($urandom_range(0, 2 * span)) - span;
    if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 1023));
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return CW'(v);
  endfunction

  task automatic rand_drive();
    int r;
    if ($urandom_range(0, 15) == 0) begin
      r = int'($urandom_range(0, 7));
      if (r < 4)       {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l} = 4'(1 << r);
      else if (r == 4) {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l} = 4'b0000;
      else             {bus.btn_d, bus.btn_u, bus.btn_r, bus.btn_l} = 4'($urandom);
    end
    if ($urandom_range(0, 31) == 0) bus.blocked = 4'($urandom & $urandom);
    for (int i = 0; i < NB; i++) begin
      bus.blast_valid[i] = ($urandom_range(0, 399) == 0);
      bus.blast_x[i*CW +: CW] = near(m_x, 90);
      bus.blast_y[i*CW +: CW] = near(m_y, 90);
    end
    bus.v_x = near(m_x + 8, 14);
    bus.v_y = near(m_y + 8, 14);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    model_reset();
    #1;
    do_reset();
    chk_en = 1'b1;

    // reset values
    @(negedge clk);
    chk("rst_pos_x", bus.pos_x, 143);
    chk("rst_pos_y", bus.pos_y, 34);
    chk("rst_facing", bus.facing, 3);
    chk("rst_lives", bus.lives, 3);
    chk("rst_moving", bus.moving, 0);
    chk("rst_game_over", bus.game_over, 0);

    // hold right: one pixel every STEP_DIV clocks
    #1 bus.btn_r = 1;
    repeat (5) @(negedge clk);
    chk("t1_pos_x_144", bus.pos_x, 144);
    chk("t1_facing_r", bus.facing, 1);
    chk("t1_moving", bus.moving, 1);
    repeat (4) @(negedge clk);
    chk("t1_pos_x_145", bus.pos_x, 145);
    #1 bus.btn_r = 0;
    @(negedge clk);
    chk("t1_release_moving", bus.moving, 0);
    chk("t1_release_pos", bus.pos_x, 145);

    // right bound clamp, then blocked mid-hold
    #1 bus.btn_r = 1;
    repeat (2600) @(negedge clk);
    chk("t2_clamp_768", bus.pos_x, 768);
    #1 bus.btn_r = 0;
    @(negedge clk);
    #1 bus.btn_l = 1;
    repeat (13) @(negedge clk);
    chk("t2_left3_765", bus.pos_x, 765);
    #1 bus.btn_l = 0;
    @(negedge clk);
    #1 bus.btn_r = 1;
    repeat (5) @(negedge clk);
    chk("t2_right1_766", bus.pos_x, 766);
    #1 bus.blocked = 4'b0010;
    repeat (20) @(negedge clk);
    chk("t2_blocked_766", bus.pos_x, 766);
    #1 bus.btn_r = 0; bus.blocked = '0;
    @(negedge clk);

    // L+U at spawn: L wins, held at MIN_X
    #1 do_reset();
    @(negedge clk);
    #1 bus.btn_l = 1; bus.btn_u = 1;
    @(negedge clk);
    chk("t3_facing_l", bus.facing, 0);
    repeat (20) @(negedge clk);
    chk("t3_pos_x", bus.pos_x, 143);
    chk("t3_pos_y", bus.pos_y, 34);
    #1 bus.btn_l = 0; bus.btn_u = 0;

    // walk to (200,100), then get hit by the horizontal arm
    #1 do_reset();
    @(negedge clk);
    #1 bus.btn_r = 1;
    repeat (229) @(negedge clk);
    chk("t4_pos_x_200", bus.pos_x, 200);
    #1 bus.btn_r = 0;
    @(negedge clk);
    #1 bus.btn_d = 1;
    repeat (265) @(negedge clk);
    chk("t4_pos_y_100", bus.pos_y, 100);
    #1 bus.btn_d = 0;
    @(negedge clk);
    #1 set_blast(0, 180, 100);
    @(negedge clk);
    chk("t4_hit_pulse", bus.hit_pulse, 1);
    chk("t4_lives_2", bus.lives, 2);
    chk("t4_respawn_x", bus.pos_x, 143);
    chk("t4_respawn_y", bus.pos_y, 34);
    #1 bus.blast_valid = '0;
    @(negedge clk);
    chk("t4_pulse_1cyc", bus.hit_pulse, 0);
    repeat (INV_CYC + 2) @(negedge clk);
    #1 set_blast(0, 300, 300);
    @(negedge clk);
    chk("t4_miss_pulse", bus.hit_pulse, 0);
    chk("t4_miss_lives", bus.lives, 2);
    #1 bus.blast_valid = '0;

    // two channels in one cycle cost one life; then the final life
    repeat (2) @(negedge clk);
    #1 set_blast(0, 150, 40); set_blast(1, 140, 30);
    @(negedge clk);
    chk("t5_dual_lives_1", bus.lives, 1);
    chk("t5_dual_pulse", bus.hit_pulse, 1);
    #1 bus.blast_valid = '0;
    repeat (INV_CYC + 2) @(negedge clk);
    #1 set_blast(0, 143, 34);
    @(negedge clk);
    chk("t5_lives_0", bus.lives, 0);
    chk("t5_game_over", bus.game_over, 1);
    #1 bus.blast_valid = '0; bus.btn_r = 1;
    repeat (20) @(negedge clk);
    chk("t5_frozen_x", bus.pos_x, 143);
    chk("t5_dead_moving", bus.moving, 0);
    #1 set_blast(0, 143, 34);
    @(negedge clk);
    chk("t5_dead_nohit", bus.hit_pulse, 0);
    #1 bus.blast_valid = '0; bus.btn_r = 0;

    // hits right after a respawn
    #1 do_reset();
    @(negedge clk);
    #1 set_blast(0, 143, 34);
    @(negedge clk);
    chk("t6_first_hit", bus.lives, 2);
`ifdef INVULN_EN
    chk("t6_invuln_on", bus.invuln, 1);
    #1 bus.blast_valid = '0;
    repeat (2) @(negedge clk);
    #1 set_blast(0, 143, 34);
    @(negedge clk);
    chk("t6_t3_ignored_pulse", bus.hit_pulse, 0);
    chk("t6_t3_ignored_lives", bus.lives, 2);
    #1 bus.blast_valid = '0;
    repeat (7) @(negedge clk);
    chk("t6_invuln_off", bus.invuln, 0);
    #1 set_blast(0, 143, 34);
    @(negedge clk);
    chk("t6_t11_pulse", bus.hit_pulse, 1);
    chk("t6_t11_lives", bus.lives, 1);
`else
    chk("t6_invuln_tied", bus.invuln, 0);
    @(negedge clk);
    chk("t6_next_cycle_lives", bus.lives, 1);
    chk("t6_next_cycle_pulse", bus.hit_pulse, 1);
`endif
    #1 bus.blast_valid = '0;

    // async reset in the middle of a move
    #1 bus.btn_d = 1;
    repeat (6) @(negedge clk);
    chk("t6_moved_y", bus.pos_y, 35);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_arst_pos_y", bus.pos_y, 34);
    chk("t6_arst_moving", bus.moving, 0);
    chk("t6_arst_lives", bus.lives, 3);
    chk("t6_arst_facing", bus.facing, 3);
    @(negedge clk);
    #1 reset_n = 1'b1; bus.btn_d = 0;

    // randomized episodes
    for (int e = 0; e < 6; e++) begin
      idle_inputs();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        #1 rand_drive();
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
